mem_port_arbiter: RTL and testbench

- Sequences port A of the shared 1024x16 dual-port sample/coefficient RAM on behalf of two requesters:
  - requester 0 is the PID control loop;
  - requester 1 is the host/debug interface.
- Supports read, write and atomic read-modify-write add.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between the requesters and RAM port A. Port B is untouched.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM port A signal bundle for mem_port_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          req1;
    logic [1:0]    op0;
    logic [1:0]    op1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          ovf;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, ram_dout,
        output ack0, ack1, rdata, ovf, busy, ram_addr, ram_din, ram_we
    );

    modport master (
        output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  ack0, ack1, rdata, ovf, busy, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for RAM port A serving the PID loop (0) and host/debug (1).
// Supports read, write, nop and atomic read-modify-write add; one transaction in flight.
module mem_port_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WB, ACK} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          gid_q, gid_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ovf_q, ovf_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_we_q, ram_we_d;
    logic          grant_c;
    logic [DW:0]   sum_ext_c;
    logic          add_ovf_c;
    logic [DW-1:0] sum_c;

    // Signed add of the word read back in WAIT and the latched addend.
    always_comb begin
        sum_ext_c = {bus.ram_dout[DW-1], bus.ram_dout} + {wdata_q[DW-1], wdata_q};
        add_ovf_c = sum_ext_c[DW] ^ sum_ext_c[DW-1];
        sum_c     = sum_ext_c[DW-1:0];
        if (SATURATE && add_ovf_c) begin
            sum_c = sum_ext_c[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ovf_d        = ovf_q;
        grant_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_c      = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
                    gid_d        = grant_c;
                    last_grant_d = grant_c;
                    op_d         = grant_c ? bus.op1    : bus.op0;
                    addr_d       = grant_c ? bus.addr1  : bus.addr0;
                    wdata_d      = grant_c ? bus.wdata1 : bus.wdata0;
                    state_d      = (op_d == OP_NOP) ? ACK : ACCESS;
                end
            end
            ACCESS: state_d = (op_q == OP_WR) ? ACK : WAIT;
            WAIT: begin
                rdata_d = bus.ram_dout;
                if (op_q == OP_ADD) begin
                    ovf_d   = add_ovf_c;
                    state_d = WB;
                end else begin
                    state_d = ACK;
                end
            end
            WB:  state_d = ACK;
            ACK: begin
                rdata_d = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        ack0_d     = (state_d == ACK) && !gid_d;
        ack1_d     = (state_d == ACK) && gid_d;
        ram_we_d   = ((state_d == ACCESS) && (op_d == OP_WR)) || (state_d == WB);
        ram_addr_d = ((state_d == ACCESS) || (state_d == WB)) ? addr_d : '0;
        ram_din_d  = '0;
        if ((state_d == ACCESS) && (op_d == OP_WR)) begin
            ram_din_d = wdata_d;
        end else if (state_d == WB) begin
            ram_din_d = sum_c;
        end
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ovf_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ovf_q        <= ovf_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata    = rdata_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.ram_we   = ram_we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a saturating and a wrapping instance share
// the same requester stimulus, each with its own dual-port RAM model.
module tb_mem_port_arbiter;
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic        pb_we;
    logic [9:0]  pb_addr;
    logic [15:0] pb_din;
    logic [15:0] pb_dout_a;
    logic [15:0] pb_dout_b;
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];
    logic [15:0] exp_cont [4];

    mem_port_arbiter_if #(.AW(10), .DW(16)) bus_a ();
    mem_port_arbiter_if #(.AW(10), .DW(16)) bus_b ();

    mem_port_arbiter #(.AW(10), .DW(16), .SATURATE(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mem_port_arbiter #(.AW(10), .DW(16), .SATURATE(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    assign bus_b.req0   = bus_a.req0;
    assign bus_b.req1   = bus_a.req1;
    assign bus_b.op0    = bus_a.op0;
    assign bus_b.op1    = bus_a.op1;
    assign bus_b.addr0  = bus_a.addr0;
    assign bus_b.addr1  = bus_a.addr1;
    assign bus_b.wdata0 = bus_a.wdata0;
    assign bus_b.wdata1 = bus_a.wdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: port A driven by each arbiter, port B shared by the bench.
    always @(posedge clk) begin
        if (bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_din;
        if (bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_din;
        if (pb_we) begin
            mem_a[pb_addr] <= pb_din;
            mem_b[pb_addr] <= pb_din;
        end
        bus_a.ram_dout <= mem_a[bus_a.ram_addr];
        bus_b.ram_dout <= mem_b[bus_b.ram_addr];
        pb_dout_a      <= mem_a[pb_addr];
        pb_dout_b      <= mem_b[pb_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        pb_addr = a;
        pb_din  = d;
        pb_we   = 1'b1;
        @(posedge clk); #1;
        pb_we   = 1'b0;
    endtask

    task automatic peek(input logic [9:0] a, output logic [15:0] da, output logic [15:0] db);
        pb_addr = a;
        @(posedge clk); #1;
        da = pb_dout_a;
        db = pb_dout_b;
    endtask

    // One transaction from an idle arbiter; checks latency, data, acks and ram_we timing.
    task automatic txn(input string tag, input logic id, input logic [1:0] op,
                       input logic [9:0] addr, input logic [15:0] wd, input int exp_lat,
                       input logic [15:0] exp_rd, input logic exp_ovf, input logic [15:0] exp_we,
                       output logic [15:0] rd_b, output logic ovf_b);
        int          cyc;
        int          lat;
        logic        seen;
        logic        other;
        logic        mine;
        logic [15:0] we_mask;
        logic [15:0] rd;
        logic        ov;
        if (id) begin
            bus_a.req1 = 1'b1; bus_a.op1 = op; bus_a.addr1 = addr; bus_a.wdata1 = wd;
        end else begin
            bus_a.req0 = 1'b1; bus_a.op0 = op; bus_a.addr0 = addr; bus_a.wdata0 = wd;
        end
        cyc = 0; lat = 0; seen = 1'b0; other = 1'b0; we_mask = '0;
        rd = '0; ov = 1'b0; rd_b = '0; ovf_b = 1'b0;
        while (!seen && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_a.ram_we) we_mask[cyc] = 1'b1;
            mine = id ? bus_a.ack1 : bus_a.ack0;
            if (id ? bus_a.ack0 : bus_a.ack1) other = 1'b1;
            if (mine) begin
                seen  = 1'b1;
                lat   = cyc;
                rd    = bus_a.rdata;
                ov    = bus_a.ovf;
                rd_b  = bus_b.rdata;
                ovf_b = bus_b.ovf;
            end
            bus_a.req0 = (id == 1'b0 && !seen) ? bus_a.req0 : 1'b0;
            bus_a.req1 = (id == 1'b1 && !seen) ? bus_a.req1 : 1'b0;
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({tag, "_ovf"}, 32'(ov), 32'(exp_ovf));
        check({tag, "_other_ack"}, 32'(other), 32'd0);
        check({tag, "_we_cycles"}, 32'(we_mask), 32'(exp_we));
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, 32'({bus_a.ack1, bus_a.ack0}), 32'd0);
        check({tag, "_idle_clear"}, 32'({bus_a.busy, bus_a.ovf, bus_a.rdata}), 32'd0);
    endtask

    initial begin
        logic [15:0] da, db, rb;
        logic        ob;
        int          k, cyc, dual, n0, n1;
        n_vec = 0;
        n_err = 0;
        exp_cont[0] = 16'h1111; exp_cont[1] = 16'h2222;
        exp_cont[2] = 16'h3333; exp_cont[3] = 16'h4444;
        reset = 1'b0;
        pb_we = 1'b0; pb_addr = '0; pb_din = '0;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        bus_a.op0 = OP_NOP; bus_a.op1 = OP_NOP;
        bus_a.addr0 = '0; bus_a.addr1 = '0;
        bus_a.wdata0 = '0; bus_a.wdata1 = '0;

        // Preload through port B while held in reset.
        poke(10'd0,  16'h0003);
        poke(10'd1,  16'h0005);
        poke(10'd2,  16'h7FF0);
        poke(10'd3,  16'h8000);
        poke(10'd10, 16'h1111);
        poke(10'd11, 16'h2222);
        poke(10'd12, 16'h3333);
        poke(10'd13, 16'h4444);
        poke(10'd20, 16'h0100);
        check("rst_outputs", 32'({bus_a.busy, bus_a.ack0, bus_a.ack1, bus_a.ovf, bus_a.ram_we}), 32'd0);
        check("rst_rdata", 32'(bus_a.rdata), 32'd0);
        check("rst_ram_addr", 32'({bus_a.ram_addr, bus_a.ram_din}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        txn("rd0", 1'b0, OP_RD, 10'd0, 16'h0000, 3, 16'h0003, 1'b0, 16'h0000, rb, ob);

        txn("add1", 1'b0, OP_ADD, 10'd1, 16'h0002, 4, 16'h0005, 1'b0, 16'h0008, rb, ob);
        peek(10'd1, da, db);
        check("add1_ram", 32'(da), 32'h0007);

        txn("sat_pos", 1'b0, OP_ADD, 10'd2, 16'h0020, 4, 16'h7FF0, 1'b1, 16'h0008, rb, ob);
        check("wrap_pos_ovf", 32'(ob), 32'd1);
        peek(10'd2, da, db);
        check("sat_pos_ram", 32'(da), 32'h7FFF);
        check("wrap_pos_ram", 32'(db), 32'h8010);

        txn("sat_neg", 1'b0, OP_ADD, 10'd3, 16'hFFFF, 4, 16'h8000, 1'b1, 16'h0008, rb, ob);
        check("wrap_neg_ovf", 32'(ob), 32'd1);
        peek(10'd3, da, db);
        check("sat_neg_ram", 32'(da), 32'h8000);
        check("wrap_neg_ram", 32'(db), 32'h7FFF);

        txn("wr513", 1'b1, OP_WR, 10'd513, 16'h0005, 2, 16'h0000, 1'b0, 16'h0002, rb, ob);
        txn("rd513", 1'b1, OP_RD, 10'd513, 16'h0000, 3, 16'h0005, 1'b0, 16'h0000, rb, ob);
        peek(10'd513, da, db);
        check("wr513_portb", 32'(da), 32'h0005);
        txn("nop1", 1'b1, OP_NOP, 10'd1023, 16'hBEEF, 1, 16'h0000, 1'b0, 16'h0000, rb, ob);

        // Contention: both held; last grant was requester 1, so 0 wins first.
        bus_a.req0 = 1'b1; bus_a.op0 = OP_RD; bus_a.addr0 = 10'd10;
        bus_a.req1 = 1'b1; bus_a.op1 = OP_RD; bus_a.addr1 = 10'd11;
        k = 0; cyc = 0; dual = 0; n0 = 0; n1 = 0;
        while (k < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_a.ack0 && bus_a.ack1) begin
                dual++;
            end else if (bus_a.ack0 || bus_a.ack1) begin
                check("cont_grant", 32'(bus_a.ack1), 32'(k % 2));
                check("cont_rdata", 32'(bus_a.rdata), 32'(exp_cont[k]));
                if (bus_a.ack0) begin
                    n0++;
                    if (n0 == 2) bus_a.req0 = 1'b0;
                    else bus_a.addr0 = 10'd12;
                end else begin
                    n1++;
                    if (n1 == 2) bus_a.req1 = 1'b0;
                    else bus_a.addr1 = 10'd13;
                end
                k++;
            end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        check("cont_count", 32'(k), 32'd4);
        check("cont_dual_ack", 32'(dual), 32'd0);
        @(posedge clk); #1;

        // Reset during the WAIT cycle of an add.
        bus_a.req0 = 1'b1; bus_a.op0 = OP_ADD; bus_a.addr0 = 10'd20; bus_a.wdata0 = 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(bus_a.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_outputs", 32'({bus_a.busy, bus_a.ram_we, bus_a.ack0, bus_a.ack1}), 32'd0);
        bus_a.req0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 32'({bus_a.busy, bus_a.ack0, bus_a.ack1}), 32'd0);
        txn("rd20", 1'b0, OP_RD, 10'd20, 16'h0000, 3, 16'h0100, 1'b0, 16'h0000, rb, ob);
        txn("rd0b", 1'b0, OP_RD, 10'd0, 16'h0000, 3, 16'h0003, 1'b0, 16'h0000, rb, ob);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
